// File: rtl/time_scheduler.sv
// Emulation time scheduler: advances emu_time by the smallest requested dt each edge.
// Optional TIME_SCHEDULER_ARGMIN_EN adds dt_sel, the index of the winning channel.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | advancing time every edge
//   PAUSE | stalled, time frozen
//   DONE  | stop time reached, waiting for start
module time_scheduler #(
  parameter int N          = 4,
  parameter int WIDTH      = 25,
  parameter int TIME_WIDTH = 40,
  parameter int DT_MAX     = (2**(WIDTH-1))-1
) (
  input  logic                          emu_clk,
  input  logic                          emu_rst_n,
  input  logic [N*WIDTH-1:0]            dt_req,
  input  logic [N-1:0]                  dt_valid,
  input  logic                          start,
  input  logic                          emu_stall,
  input  logic                          stop_en,
  input  logic [TIME_WIDTH-1:0]         stop_time,
  output logic signed [WIDTH-1:0]       emu_dt,
  output logic [TIME_WIDTH-1:0]         emu_time,
  output logic                          running,
  output logic                          done,
  output logic                          time_ovf
`ifdef TIME_SCHEDULER_ARGMIN_EN
  ,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] dt_sel
`endif
);

  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] DT_MAX_V = WIDTH'(DT_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        dt_d;
  logic [TIME_WIDTH-1:0]   time_d;
  logic                    ovf_d;

  logic [WIDTH-1:0]        req_k;
  logic [WIDTH-1:0]        val_k;
  logic [WIDTH-1:0]        best;
  logic                    found;
  logic [WIDTH-1:0]        cand;
  logic [TIME_WIDTH:0]     rem;
  logic [TIME_WIDTH:0]     cand_ext;
  logic [WIDTH-1:0]        step;
  logic [TIME_WIDTH:0]     sum;
  logic                    advance;
`ifdef TIME_SCHEDULER_ARGMIN_EN
  logic [SEL_W-1:0]        win;
  logic [SEL_W-1:0]        sel_d;
  logic [SEL_W-1:0]        sel_q;
  assign dt_sel = sel_q;
`endif

  // Negative requests count as zero; strict compare keeps the lowest index on ties.
  always_comb begin
    req_k = '0;
    val_k = '0;
    best  = '0;
    found = 1'b0;
`ifdef TIME_SCHEDULER_ARGMIN_EN
    win   = '0;
`endif
    for (int k = 0; k < N; k++) begin
      req_k = dt_req[k*WIDTH +: WIDTH];
      val_k = req_k[WIDTH-1] ? '0 : req_k;
      if (dt_valid[k] && (!found || (val_k < best))) begin
        best  = val_k;
        found = 1'b1;
`ifdef TIME_SCHEDULER_ARGMIN_EN
        win   = k[SEL_W-1:0];
`endif
      end
    end
    if (!found || (best > DT_MAX_V)) cand = DT_MAX_V;
    else                              cand = best;
  end

  assign rem      = {1'b0, stop_time} - {1'b0, emu_time};
  assign cand_ext = {{(TIME_WIDTH+1-WIDTH){1'b0}}, cand};

  always_comb begin
    state_d = state_q;
    dt_d    = '0;
    time_d  = emu_time;
    ovf_d   = time_ovf;
    advance = 1'b0;
    step    = cand;
    sum     = '0;
`ifdef TIME_SCHEDULER_ARGMIN_EN
    sel_d   = '0;
`endif
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (emu_stall) state_d = PAUSE;
               else advance = 1'b1;
      PAUSE:   if (!emu_stall) begin
                 state_d = RUN;
                 advance = 1'b1;
               end
      DONE:    if (start) begin
                 state_d = RUN;
                 time_d  = '0;
                 ovf_d   = 1'b0;
               end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      // rem is signed by its top bit: zero or negative means the stop time is already passed.
      if (stop_en && (rem[TIME_WIDTH] || (rem == '0))) begin
        step    = '0;
        state_d = DONE;
      end else if (stop_en && (cand_ext >= rem)) begin
        step    = rem[WIDTH-1:0];
        state_d = DONE;
      end
      sum    = {1'b0, emu_time} + {{(TIME_WIDTH+1-WIDTH){1'b0}}, step};
      time_d = sum[TIME_WIDTH-1:0];
      if (sum[TIME_WIDTH]) ovf_d = 1'b1;
      dt_d   = step;
`ifdef TIME_SCHEDULER_ARGMIN_EN
      sel_d  = found ? win : '0;
`endif
    end
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q  <= IDLE;
      emu_dt   <= '0;
      emu_time <= '0;
      time_ovf <= 1'b0;
`ifdef TIME_SCHEDULER_ARGMIN_EN
      sel_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      emu_dt   <= dt_d;
      emu_time <= time_d;
      time_ovf <= ovf_d;
`ifdef TIME_SCHEDULER_ARGMIN_EN
      sel_q    <= sel_d;
`endif
    end
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_time_scheduler.sv
// Directed bench for time_scheduler with an integer-level reference model and per-cycle compare.
module tb_time_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TW = 10;
  localparam int DM = 100;

  logic            emu_clk = 1'b0;
  logic            emu_rst_n = 1'b0;
  logic [N*W-1:0]  dt_req = '0;
  logic [N-1:0]    dt_valid = '0;
  logic            start = 1'b0;
  logic            emu_stall = 1'b0;
  logic            stop_en = 1'b0;
  logic [TW-1:0]   stop_time = '0;
  logic signed [W-1:0] emu_dt;
  logic [TW-1:0]   emu_time;
  logic            running, done, time_ovf;
`ifdef TIME_SCHEDULER_ARGMIN_EN
  logic [1:0]      dt_sel;
`endif

  time_scheduler #(.N(N), .WIDTH(W), .TIME_WIDTH(TW), .DT_MAX(DM)) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .dt_req(dt_req), .dt_valid(dt_valid),
    .start(start), .emu_stall(emu_stall), .stop_en(stop_en), .stop_time(stop_time),
    .emu_dt(emu_dt), .emu_time(emu_time), .running(running), .done(done),
    .time_ovf(time_ovf)
`ifdef TIME_SCHEDULER_ARGMIN_EN
    , .dt_sel(dt_sel)
`endif
  );

  always #5 emu_clk = ~emu_clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 run, 2 pause, 3 done.
  int     m_mode = 0;
  longint m_time = 0;
  longint m_dt   = 0;
  int     m_sel  = 0;
  bit     m_ovf  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pin(input string nm, input longint dut_v, input longint mdl_v, input longint exp);
    chk(nm, dut_v, exp);
    chk({nm, "_model"}, mdl_v, exp);
  endtask

  always @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      m_mode = 0; m_time = 0; m_dt = 0; m_sel = 0; m_ovf = 0;
    end else begin
      longint c, rem, step;
      int     s;
      c = -1; s = 0;
      for (int k = 0; k < N; k++) begin
        longint v;
        v = $signed(dt_req[k*W +: W]);
        if (v < 0) v = 0;
        if (dt_valid[k] && (c < 0 || v < c)) begin c = v; s = k; end
      end
      if (c < 0) begin c = DM; s = 0; end
      else if (c > DM) c = DM;
      m_dt = 0; m_sel = 0;
      if (m_mode == 0) begin
        if (start) m_mode = 1;
      end else if (m_mode == 3) begin
        if (start) begin m_mode = 1; m_time = 0; m_ovf = 0; end
      end else if (emu_stall) begin
        m_mode = 2;
      end else begin
        m_mode = 1;
        step = c;
        if (stop_en) begin
          rem = longint'(stop_time) - m_time;
          if (rem <= 0) begin step = 0; m_mode = 3; end
          else if (c >= rem) begin step = rem; m_mode = 3; end
        end
        m_time = m_time + step;
        if (m_time >= (longint'(1) << TW)) begin m_time -= (longint'(1) << TW); m_ovf = 1; end
        m_dt = step; m_sel = s;
      end
    end
  end

  always @(negedge emu_clk) begin
    if (chk_en) begin
      chk("emu_dt", longint'(emu_dt), m_dt);
      chk("emu_time", longint'(emu_time), m_time);
      chk("running", longint'(running), longint'(m_mode == 1));
      chk("done", longint'(done), longint'(m_mode == 3));
      chk("time_ovf", longint'(time_ovf), longint'(m_ovf));
`ifdef TIME_SCHEDULER_ARGMIN_EN
      chk("dt_sel", longint'(dt_sel), longint'(m_sel));
`endif
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge emu_clk);
      #1;
    end
  endtask

  task automatic set_req(input int a, input int b, input int c, input int d);
    dt_req = {W'(d), W'(c), W'(b), W'(a)};
  endtask

  initial begin
    tick(2);
    chk_en = 1'b1;
    pin("rst_dt", longint'(emu_dt), m_dt, 0);
    pin("rst_time", longint'(emu_time), m_time, 0);
    chk("rst_running", longint'(running), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ovf", longint'(time_ovf), 0);
    emu_rst_n = 1'b1;
    tick();

    // basic run: min of {40,10,30,10} is 10, tie picks channel 1
    set_req(40, 10, 30, 10); dt_valid = 4'b1111; start = 1'b1;
    tick();
    pin("start_dt", longint'(emu_dt), m_dt, 0);
    start = 1'b0;
    tick(3);
    pin("run_dt", longint'(emu_dt), m_dt, 10);
    pin("run_time", longint'(emu_time), m_time, 30);
`ifdef TIME_SCHEDULER_ARGMIN_EN
    pin("run_sel", longint'(dt_sel), longint'(m_sel), 1);
`endif
    start = 1'b1; tick(); start = 1'b0;
    pin("start_ignored", longint'(emu_time), m_time, 40);

    // no valid channel -> DT_MAX; lone negative -> 0; over-range -> clamp; tie
    dt_valid = 4'b0000;
    tick(2);
    pin("novalid_dt", longint'(emu_dt), m_dt, 100);
    pin("novalid_time", longint'(emu_time), m_time, 240);
    set_req(40, 10, -5, 10); dt_valid = 4'b0100;
    tick();
    pin("neg_dt", longint'(emu_dt), m_dt, 0);
    set_req(120, 0, 0, 0); dt_valid = 4'b0001;
    tick();
    pin("clamp_dt", longint'(emu_dt), m_dt, 100);
    set_req(7, 9, 3, 3); dt_valid = 4'b1111;
    tick();
    pin("tie_dt", longint'(emu_dt), m_dt, 3);
`ifdef TIME_SCHEDULER_ARGMIN_EN
    pin("tie_sel", longint'(dt_sel), longint'(m_sel), 2);
`endif

    // stall for three edges; stop condition present but stall wins
    emu_stall = 1'b1; stop_en = 1'b1; stop_time = '0;
    tick(3);
    pin("stall_time", longint'(emu_time), m_time, 343);
    pin("stall_dt", longint'(emu_dt), m_dt, 0);
    chk("stall_running", longint'(running), 0);
    chk("stall_done", longint'(done), 0);
    emu_stall = 1'b0; stop_en = 1'b0;
    tick();
    pin("unstall_time", longint'(emu_time), m_time, 346);

    // stop at 360 with candidate 10
    set_req(10, 20, 30, 40); dt_valid = 4'b0001; stop_en = 1'b1; stop_time = 10'd360;
    tick();
    pin("prestop_time", longint'(emu_time), m_time, 356);
    tick();
    pin("stop_dt", longint'(emu_dt), m_dt, 4);
    pin("stop_time", longint'(emu_time), m_time, 360);
    chk("stop_done", longint'(done), 1);
    tick(2);
    pin("done_hold_dt", longint'(emu_dt), m_dt, 0);
    pin("done_hold_time", longint'(emu_time), m_time, 360);
    stop_time = '0; start = 1'b1;
    tick();
    pin("restart_time", longint'(emu_time), m_time, 0);
    chk("restart_running", longint'(running), 1);
    start = 1'b0;
    tick();
    chk("zero_rem_done", longint'(done), 1);
    pin("zero_rem_dt", longint'(emu_dt), m_dt, 0);
    start = 1'b1; stop_en = 1'b0;
    tick();
    start = 1'b0;

    // wrap through 2**10
    dt_valid = 4'b0000;
    tick(10);
    pin("pre_wrap_time", longint'(emu_time), m_time, 1000);
    set_req(20, 0, 0, 0); dt_valid = 4'b0001;
    tick();
    set_req(10, 0, 0, 0);
    tick();
    pin("wrap_time", longint'(emu_time), m_time, 6);
    pin("wrap_ovf", longint'(time_ovf), longint'(m_ovf), 1);
    tick();
    pin("ovf_sticky", longint'(time_ovf), longint'(m_ovf), 1);
    stop_en = 1'b1; stop_time = '0;
    tick();
    chk("past_stop_done", longint'(done), 1);
    stop_en = 1'b0; start = 1'b1;
    tick();
    pin("restart_ovf", longint'(time_ovf), longint'(m_ovf), 0);
    start = 1'b0;
    tick(2);

    // asynchronous reset mid-run
    emu_rst_n = 1'b0;
    #1;
    pin("arst_time", longint'(emu_time), m_time, 0);
    pin("arst_dt", longint'(emu_dt), m_dt, 0);
    chk("arst_running", longint'(running), 0);
    chk("arst_ovf", longint'(time_ovf), 0);
    tick();
    emu_rst_n = 1'b1;
    tick(2);
    chk("post_rst_idle", longint'(running), 0);
    pin("post_rst_time", longint'(emu_time), m_time, 0);
    start = 1'b1; tick(); start = 1'b0;
    tick(2);
    pin("post_rst_run", longint'(emu_time), m_time, 20);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_scheduler.md
TIME_SCHEDULER -- requirements
Module: time_scheduler

Interface
REQ-001 Parameter: N, 4, number of dt request channels (>=1).
REQ-002 Parameter: WIDTH, 25, signed width of dt requests and emu_dt.
REQ-003 Parameter: TIME_WIDTH, 40, width of emu_time (> WIDTH).
REQ-004 Parameter: DT_MAX, 2**(WIDTH-1)-1, upper clamp for any advance.
REQ-005 Reset is asynchronous and active-low; one clock: emu_clk  in  1  emulator clock; emu_rst_n  in  1  async active-low reset.
REQ-006 dt_req  in  WIDTH x N signed  per-channel requested step.
REQ-007 dt_valid  in  N  per-channel request enable mask.
REQ-008 start  in  1  pulse: leave IDLE/DONE and run.
REQ-009 emu_stall  in  1  freeze time while high.
REQ-010 stop_en  in  1  enable stop-time limit; stop_time  in  TIME_WIDTH unsigned  stop target.
REQ-011 emu_dt  out  WIDTH signed  registered step applied at last edge; emu_time  out  TIME_WIDTH  registered emulation time.
REQ-012 running  out  1  state==RUN; done  out  1  state==DONE; time_ovf  out  1  sticky wrap flag.

Function
REQ-013 Candidate = minimum of dt_req[k] over k with dt_valid[k]=1, negative requests treated as 0, result clamped to DT_MAX; no valid channel -> DT_MAX; ties -> lowest index.
REQ-014 States IDLE, RUN, PAUSE, DONE; reset -> IDLE.
REQ-015 IDLE: start=1 -> RUN; no advance on that edge.
REQ-016 RUN: emu_stall=1 -> PAUSE, emu_dt<=0, time held; PAUSE: emu_stall=0 -> RUN, and that edge advances.
REQ-017 Advancing edge (RUN, or PAUSE with emu_stall=0): emu_dt<=step, emu_time<=emu_time+step (step zero-extended); latency one edge from request sample to both outputs.
REQ-018 Non-advancing edges (IDLE, DONE, stall) SHALL load emu_dt<=0 and hold emu_time.
REQ-019 Stop: on advancing edge with stop_en=1, remaining=stop_time-emu_time; if remaining<=0 step=0 and DONE; else if candidate>=remaining step=remaining, emu_time<=stop_time, DONE; else normal.
REQ-020 Stall has priority over stop; start ignored in RUN/PAUSE.
REQ-021 DONE: start=1 -> RUN, emu_time<=0, time_ovf<=0, emu_dt<=0 on that edge.
REQ-022 emu_time wraps modulo 2**TIME_WIDTH; carry-out sets time_ovf, sticky until reset or restart.
REQ-023 stop_time, stop_en, dt_req, dt_valid are sampled only on the edge that uses them; no input registering.

Reset
REQ-024 emu_rst_n=0 asynchronously: state=IDLE, emu_dt=0, emu_time=0, time_ovf=0, running=0, done=0 (and dt_sel=0 if present).
REQ-025 Reset asserted mid-RUN discards in-flight step; release -> IDLE awaiting start.

Configuration
REQ-026 Macro TIME_SCHEDULER_ARGMIN_EN defined: add output dt_sel  out  $clog2(N) (min 1)  index of winning channel, registered with emu_dt; 0 when no channel valid or on non-advancing edges.
REQ-027 Macro undefined: dt_sel port and argmin logic absent; all other behaviour identical.

Verification
REQ-028 N=4, start, dt_req={40,10,30,10}, all valid -> emu_dt=10 one edge later, emu_time 10,20,30; dt_sel=1 (macro on).
REQ-029 dt_valid=4'b0000 in RUN, DT_MAX=100 -> emu_dt=100 each edge; dt_req[2]=-5 valid alone -> emu_dt=0.
REQ-030 RUN at time 50, emu_stall high 3 edges -> emu_dt=0, time 50 held, state PAUSE; stall low -> next edge advances.
REQ-031 stop_en=1, stop_time=95, time 90, candidate 10 -> emu_dt=5, emu_time=95, done=1; further edges emu_dt=0; start -> emu_time=0, RUN.
REQ-032 TIME_WIDTH=8, time 250, step 10 -> emu_time=4, time_ovf=1 sticky; emu_rst_n low mid-RUN -> all outputs 0 immediately, IDLE.
